// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN layer sequencer: instruction bit positions,
// FSM state encoding and default geometry.
package bnn_pkg;

    localparam int NGRP_DEF     = 4;
    localparam int LOAD_CYC_DEF = 3;
    localparam int PSUM_LAT_DEF = 2;
    localparam int INSTR_W      = 23;

    localparam int INS_CLR   = 0;
    localparam int INS_SEL   = 1;   // bpug_sel [4:1]
    localparam int INS_SUBHI = 6;   // bpug ctl bit 1: pool sub-pixel MSB / store half
    localparam int INS_CFG   = 8;   // bpug ctl bit 3: core latches config
    localparam int INS_PSUM  = 9;
    localparam int INS_BIN   = 10;
    localparam int INS_BIAS  = 11;
    localparam int INS_POOL  = 12;
    localparam int INS_PSEL  = 13;
    localparam int INS_STORE = 14;
    localparam int INS_IMG   = 15;
    localparam int INS_ISEL  = 16;
    localparam int INS_WGT   = 17;  // wgt_sel [19:17]

    typedef logic [3:0] state_e;

    localparam state_e S_IDLE     = 4'd0;
    localparam state_e S_CFG      = 4'd1;
    localparam state_e S_BIAS0    = 4'd2;
    localparam state_e S_BIAS1    = 4'd3;
    localparam state_e S_CLR      = 4'd4;
    localparam state_e S_LOAD     = 4'd5;
    localparam state_e S_WAIT     = 4'd6;
    localparam state_e S_ADD      = 4'd7;
    localparam state_e S_BIN      = 4'd8;
    localparam state_e S_STORE_LO = 4'd9;
    localparam state_e S_STORE_HI = 4'd10;

endpackage

// File: rtl/bnn_instr_encode.sv
// Combinational mapping of sequencer state and counters onto the 23-bit core
// instruction word; consuming states emit a bubble while the input stalls.
module bnn_instr_encode
    import bnn_pkg::*;
(
    input  state_e             state_i,
    input  logic [3:0]         grp_i,
    input  logic [2:0]         row_i,
    input  logic [1:0]         sub_i,
    input  logic               pool_i,
    input  logic               in_valid_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               consume_o
);

    always_comb begin
        instr_o   = '0;
        consume_o = (state_i == S_CFG) || (state_i == S_BIAS0) ||
                    (state_i == S_BIAS1) || (state_i == S_LOAD);
        case (state_i)
            S_CFG: begin
                if (in_valid_i) begin
                    instr_o[INS_IMG] = 1'b1;
                    instr_o[INS_CFG] = 1'b1;
                end
            end
            S_BIAS0, S_BIAS1: begin
                if (in_valid_i) instr_o[INS_BIAS] = 1'b1;
            end
            S_CLR: instr_o[INS_CLR] = 1'b1;
            S_LOAD: begin
                // bpug ctl stays 0 here so the core does not reload its config
                if (in_valid_i) begin
                    instr_o[INS_IMG]        = 1'b1;
                    instr_o[INS_ISEL]       = row_i[0];
                    instr_o[INS_WGT +: 3]   = row_i;
                    instr_o[INS_SEL +: 4]   = grp_i;
                end
            end
            S_WAIT: instr_o[INS_SEL +: 4] = grp_i;
            S_ADD: begin
                instr_o[INS_PSUM]     = 1'b1;
                instr_o[INS_SEL +: 4] = grp_i;
            end
            S_BIN: begin
                instr_o[INS_BIN] = 1'b1;
                if (pool_i) begin
                    instr_o[INS_POOL]  = 1'b1;
                    instr_o[INS_SUBHI] = sub_i[1];
                    instr_o[INS_PSEL]  = sub_i[0];
                end
            end
            S_STORE_LO: instr_o[INS_STORE] = 1'b1;
            S_STORE_HI: begin
                instr_o[INS_STORE] = 1'b1;
                instr_o[INS_SUBHI] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Instruction-issuing master for one BNN compute core: walks config, biases and
// per-pixel load/add/binarise/pool, then streams stored result words out.
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int NGRP     = NGRP_DEF,
    parameter int LOAD_CYC = LOAD_CYC_DEF,
    parameter int PSUM_LAT = PSUM_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cfg_pool,
    input  logic [8:0]         cfg_nout,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [31:0]        core_data,
    input  logic [31:0]        result_bins,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    state_e      state_q, state_d;
    logic [3:0]  grp_q, grp_d;
    logic [2:0]  row_q, row_d;
    logic [1:0]  sub_q, sub_d;
    logic [8:0]  pix_q, pix_d;
    logic [8:0]  nout_q, nout_d;
    logic        pool_q, pool_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        consume;
    logic [8:0]  pix_inc;

    bnn_instr_encode u_encode (
        .state_i    (state_q),
        .grp_i      (grp_q),
        .row_i      (row_q),
        .sub_i      (sub_q),
        .pool_i     (pool_q),
        .in_valid_i (in_valid),
        .instr_o    (instruction),
        .consume_o  (consume)
    );

    assign in_ready  = consume;
    assign core_data = (consume && in_valid) ? in_data : 32'd0;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_inc   = pix_q + 9'd1;

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        row_d       = row_q;
        sub_d       = sub_q;
        pix_d       = pix_q;
        nout_d      = nout_q;
        pool_d      = pool_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CFG;
                    busy_d  = 1'b1;
                    pool_d  = cfg_pool;
                    nout_d  = (cfg_nout == 9'd0) ? 9'd1 : cfg_nout;
                    pix_d   = 9'd0;
                    grp_d   = 4'd0;
                    row_d   = 3'd0;
                    sub_d   = 2'd0;
                end
            end
            S_CFG:   if (in_valid) state_d = S_BIAS0;
            S_BIAS0: if (in_valid) state_d = S_BIAS1;
            S_BIAS1: if (in_valid) state_d = S_CLR;
            S_CLR: begin
                state_d = S_LOAD;
                row_d   = 3'd0;
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (row_q == 3'(LOAD_CYC - 1)) begin
                        row_d   = 3'd0;
                        state_d = (PSUM_LAT == 0) ? S_ADD : S_WAIT;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            S_WAIT: begin
                if (row_q == 3'(PSUM_LAT - 1)) begin
                    row_d   = 3'd0;
                    state_d = S_ADD;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end
            S_ADD: begin
                if (grp_q == 4'(NGRP - 1)) begin
                    grp_d   = 4'd0;
                    state_d = S_BIN;
                end else begin
                    grp_d   = grp_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_BIN: begin
                // Output pixel completes on the last pooled sub-pixel; store every 8 or at the end
                if (!pool_q || sub_q == 2'd3) begin
                    sub_d   = 2'd0;
                    pix_d   = pix_inc;
                    state_d = (pix_inc[2:0] == 3'd0 || pix_inc == nout_q) ? S_STORE_LO : S_CLR;
                end else begin
                    sub_d   = sub_q + 2'd1;
                    state_d = S_CLR;
                end
            end
            S_STORE_LO, S_STORE_HI: begin
                if (!out_valid_q) begin
                    out_data_d  = result_bins;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (state_q == S_STORE_LO) begin
                        state_d = S_STORE_HI;
                    end else if (pix_q == nout_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grp_q       <= 4'd0;
            row_q       <= 3'd0;
            sub_q       <= 2'd0;
            pix_q       <= 9'd0;
            nout_q      <= 9'd0;
            pool_q      <= 1'b0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            row_q       <= row_d;
            sub_q       <= sub_d;
            pix_q       <= pix_d;
            nout_q      <= nout_d;
            pool_q      <= pool_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: expected per-cycle instruction stream built from
// the job description, compared each cycle, plus literal totals per job.
module tb_bnn_layer_sequencer;

    localparam int NG = 4;
    localparam int LC = 3;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cfg_pool = 1'b0;
    logic [8:0]  cfg_nout = 9'd0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] instruction;
    logic [31:0] core_data;
    logic [31:0] result_bins = 32'd0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    bnn_layer_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_pool    (cfg_pool),
        .cfg_nout    (cfg_nout),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .core_data   (core_data),
        .result_bins (result_bins),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] ins;
        bit          cons;
        bit          store;
        bit          last;
    } step_t;

    step_t       q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          mode = 1;
    int          win, wout, dones, bubbles, busy_cyc, bin_n, bin_pool_bad;
    logic [1:0]  bin_sub[64];
    logic [22:0] first_ins;
    bit          rec_first = 0;
    bit          st_first = 1;
    bit          exp_done = 0;
    logic [31:0] exp_out = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input int ins, input bit cons, input bit store, input bit last);
        step_t s;
        s.ins   = 23'(ins);
        s.cons  = cons;
        s.store = store;
        s.last  = last;
        return s;
    endfunction

    // Expected instruction stream of a whole job, one entry per non-stalled cycle
    task automatic build(input bit pool, input logic [8:0] nraw);
        int n;
        int subs;
        int bin;
        n    = (nraw == 9'd0) ? 1 : int'(nraw);
        subs = pool ? 4 : 1;
        q.push_back(mk(32'h8100, 1, 0, 0));
        q.push_back(mk(1 << 11, 1, 0, 0));
        q.push_back(mk(1 << 11, 1, 0, 0));
        for (int p = 0; p < n; p++) begin
            for (int sb = 0; sb < subs; sb++) begin
                q.push_back(mk(1, 0, 0, 0));
                for (int g = 0; g < NG; g++) begin
                    for (int r = 0; r < LC; r++)
                        q.push_back(mk(32'h8000 | ((r & 1) << 16) | (r << 17) | (g << 1), 1, 0, 0));
                    for (int w = 0; w < PL; w++)
                        q.push_back(mk(g << 1, 0, 0, 0));
                    q.push_back(mk((1 << 9) | (g << 1), 0, 0, 0));
                end
                bin = 1 << 10;
                if (pool) bin = bin | (1 << 12) | (((sb >> 1) & 1) << 6) | ((sb & 1) << 13);
                q.push_back(mk(bin, 0, 0, 0));
            end
            if (((p + 1) % 8 == 0) || (p + 1 == n)) begin
                q.push_back(mk(1 << 14, 0, 1, 0));
                q.push_back(mk((1 << 14) | (1 << 6), 0, 1, p + 1 == n));
            end
        end
    endtask

    // Per-cycle comparison against the expected stream
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            st_first = 1;
            exp_done = 0;
            rec_first = 0;
        end else begin
            chk("done", {31'd0, done}, {31'd0, exp_done});
            exp_done = 0;
            if (done) dones++;
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            if (busy) busy_cyc++;
            if (rec_first) begin
                first_ins = instruction;
                rec_first = 0;
            end
            if (q.size() == 0) begin
                chk("idle_instr", {9'd0, instruction}, 32'd0);
                chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
                chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
                if (start) begin
                    build(cfg_pool, cfg_nout);
                    rec_first = 1;
                    st_first = 1;
                end
            end else begin
                step_t h;
                h = q[0];
                chk("in_ready", {31'd0, in_ready}, {31'd0, h.cons});
                chk("out_valid", {31'd0, out_valid}, {31'd0, h.store && !st_first});
                if (instruction[10] && bin_n < 64) begin
                    bin_sub[bin_n] = {instruction[6], instruction[13]};
                    if (!instruction[12]) bin_pool_bad++;
                    bin_n++;
                end
                if (h.cons) begin
                    if (!in_valid) begin
                        chk("stall_instr", {9'd0, instruction}, 32'd0);
                        chk("stall_core_data", core_data, 32'd0);
                        bubbles++;
                    end else begin
                        chk("instr", {9'd0, instruction}, {9'd0, h.ins});
                        chk("core_data", core_data, in_data);
                        win++;
                        void'(q.pop_front());
                    end
                end else if (h.store) begin
                    chk("store_instr", {9'd0, instruction}, {9'd0, h.ins});
                    if (st_first) begin
                        exp_out = result_bins;
                        st_first = 0;
                    end else begin
                        chk("out_data", out_data, exp_out);
                        if (out_ready) begin
                            wout++;
                            st_first = 1;
                            if (h.last) exp_done = 1;
                            void'(q.pop_front());
                        end
                    end
                end else begin
                    chk("instr", {9'd0, instruction}, {9'd0, h.ins});
                    chk("core_data_idle", core_data, 32'd0);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Input driver: 0 random, 1 always ready/valid, 2 five-cycle LOAD stall, 3 four-cycle store backpressure
    initial begin
        int st_cnt;
        int hold;
        st_cnt = 0;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            in_data     = $urandom;
            result_bins = $urandom;
            if (mode == 0) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                st_cnt = 0;
                hold = 0;
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b1;
                if (mode == 2) begin
                    if (st_cnt > 0 && st_cnt < 5) begin
                        in_valid = 1'b0;
                        st_cnt++;
                    end else if (st_cnt == 0 && instruction[15] && !instruction[8] &&
                                 instruction[19:17] == 3'd1) begin
                        in_valid = 1'b0;
                        st_cnt = 1;
                    end
                end else begin
                    st_cnt = 0;
                end
                if (mode == 3) begin
                    if (out_valid && instruction[14] && !instruction[6] && hold < 4) begin
                        out_ready = 1'b0;
                        hold++;
                    end
                end else begin
                    hold = 0;
                end
            end
        end
    end

    task automatic clear_counts();
        win = 0; wout = 0; dones = 0; bubbles = 0; busy_cyc = 0; bin_n = 0; bin_pool_bad = 0;
    endtask

    task automatic run_job(input bit pool, input int nout, input int md, input bit glitch);
        bit fin;
        fin = 0;
        mode = md;
        clear_counts();
        @(posedge clk);
        #2;
        cfg_pool = pool;
        cfg_nout = 9'(nout);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (glitch && c == 10) begin
                #2;
                cfg_pool = ~pool;
                cfg_nout = 9'd3;
                start = 1'b1;
                @(posedge clk);
                #2;
                start = 1'b0;
            end
            if (dones > 0) begin
                fin = 1;
                break;
            end
        end
        if (!fin) chk("job_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        mode = 1;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr", {9'd0, instruction}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        #2;
        rst = 1'b1;

        run_job(0, 1, 1, 0);
        chk("j1_cfg_instr", {9'd0, first_ins}, 32'h0000_8100);
        chk("j1_busy_cycles", busy_cyc, 33);
        chk("j1_words_in", win, 15);
        chk("j1_words_out", wout, 2);
        chk("j1_done_pulses", dones, 1);

        run_job(0, 8, 1, 0);
        chk("n8_words_in", win, 99);
        chk("n8_words_out", wout, 2);

        run_job(1, 1, 1, 0);
        chk("pool_words_in", win, 51);
        chk("pool_words_out", wout, 2);
        chk("pool_bin_count", bin_n, 4);
        chk("pool_bin_en", bin_pool_bad, 0);
        for (int i = 0; i < 4; i++) chk("pool_bin_sub", {30'd0, bin_sub[i]}, i);

        run_job(0, 1, 2, 0);
        chk("stall_bubbles", bubbles, 5);
        chk("stall_busy_cycles", busy_cyc, 38);

        run_job(0, 1, 3, 0);
        chk("bp_busy_cycles", busy_cyc, 37);
        chk("bp_words_out", wout, 2);

        run_job(0, 9, 0, 0);
        chk("n9_words_out", wout, 4);
        chk("n9_words_in", win, 3 + 9 * 12);

        run_job(0, 0, 1, 0);
        chk("n0_words_in", win, 15);
        chk("n0_words_out", wout, 2);

        for (int j = 0; j < 6; j++) begin
            bit p;
            int n;
            p = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 12);
            run_job(p, n, 0, j == 0);
            chk("rnd_words_in", win, 3 + n * (p ? 4 : 1) * 12);
            chk("rnd_words_out", wout, 2 * ((n + 7) / 8));
            chk("rnd_done", dones, 1);
        end

        // Reset in the middle of a LOAD with the input stream still valid
        mode = 1;
        clear_counts();
        @(posedge clk);
        #2;
        cfg_pool = 1'b0;
        cfg_nout = 9'd2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk);
                #2;
                if (instruction[15] && !instruction[8] && in_valid) begin
                    seen = 1;
                    break;
                end
            end
            chk("mr_reached_load", {31'd0, seen}, 32'd1);
        end
        #1;
        rst = 1'b0;
        #1;
        chk("mr_instr", {9'd0, instruction}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_core_data", core_data, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_idle_busy", {31'd0, busy}, 32'd0);
        chk("mr_idle_instr", {9'd0, instruction}, 32'd0);

        run_job(0, 1, 1, 0);
        chk("mr_restart_cfg", {9'd0, first_ins}, 32'h0000_8100);
        chk("mr_restart_words_in", win, 15);
        chk("mr_restart_words_out", wout, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
